// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: MEM/WB pipeline writes win, NPU results queue in a small FIFO.
// Latency: a selected write appears on WR/WD/RegWrite one cycle later; NPU results take at least 2 cycles.
// Backpressure: npu_ready drops when the FIFO is full; stall freezes MEM/WB for one cycle to force a drain.
module wb_arbiter #(
  parameter int DEPTH   = 4,
  parameter int AGE_MAX = 8
) (
  input  logic                     clk_50,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  input  logic                     npu_valid,
  input  logic [4:0]               npu_rd,
  input  logic [31:0]              npu_data,
  output logic                     npu_ready,
  output logic [4:0]               WR,
  output logic [31:0]              WD,
  output logic                     RegWrite,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = (AGE_MAX > 1) ? $clog2(AGE_MAX) : 1;
  localparam logic [AW-1:0] AGE_TOP = AW'(AGE_MAX - 1);

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_sq;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_age;
  logic [4:0]       r_wr;
  logic [31:0]      r_wd;
  logic             r_we;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_pipe_sel;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign npu_ready  = !rst && !w_full;
  // x0 results are accepted (handshake completes) but never occupy a slot
  assign w_push     = npu_valid && npu_ready && (npu_rd != 5'd0);
  assign stall      = (r_state == S_DRAIN);
  assign fifo_count = r_count;
  assign WR         = r_wr;
  assign WD         = r_wd;
  assign RegWrite   = r_we;

  // State register: DRAIN lasts exactly one cycle
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Source selection and next state; DRAIN ignores wb_we because MEM/WB re-presents it afterwards
  always_comb begin
    w_state_nxt = r_state;
    w_pipe_sel  = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_pipe_sel = wb_we && (wb_rd != 5'd0);
        w_pop      = !w_pipe_sel && !w_empty;
        if ((r_age == AGE_TOP && !w_empty) || (w_full && w_pipe_sel))
          w_state_nxt = S_DRAIN;
      end
      default: begin
        w_pop       = !w_empty;
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // Payload storage; slots are only read after being written, so no reset is needed
  always_ff @(posedge clk_50) begin
    if (w_push) begin
      r_rd[r_wptr]   <= npu_rd;
      r_data[r_wptr] <= npu_data;
    end
  end

  // Squash flags: a selected pipeline write makes any queued (or just-arriving) result to the same rd stale
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_sq <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pipe_sel && (r_rd[i] == wb_rd)) r_sq[i] <= 1'b1;
      end
      if (w_push) r_sq[r_wptr] <= w_pipe_sel && (npu_rd == wb_rd);
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Head age: counts starved cycles, saturating at the value that forces a drain
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst)                   r_age <= '0;
    else if (w_pop || w_empty) r_age <= '0;
    else if (r_age != AGE_TOP) r_age <= r_age + AW'(1);
  end

  // Registered write port; address/data hold when nothing is written
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_wd <= '0;
      r_we <= 1'b0;
    end else if (w_pipe_sel) begin
      r_wr <= wb_rd;
      r_wd <= wb_data;
      r_we <= 1'b1;
    end else if (w_pop && !r_sq[r_rptr]) begin
      r_wr <= r_rd[r_rptr];
      r_wd <= r_data[r_rptr];
      r_we <= 1'b1;
    end else begin
      r_we <= 1'b0;
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: NPU result FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter AGE_MAX, default 8: cycles the FIFO head may wait before a forced drain.
REQ-003 SHALL have port clk_50, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port wb_we, input, 1: MEM/WB stage requests a register write.
REQ-006 SHALL have port wb_rd, input, 5: MEM/WB destination register.
REQ-007 SHALL have port wb_data, input, 32: MEM/WB write data.
REQ-008 SHALL have port npu_valid, input, 1: NPU presents a result.
REQ-009 SHALL have port npu_rd, input, 5: NPU result destination register.
REQ-010 SHALL have port npu_data, input, 32: NPU result data.
REQ-011 SHALL have port npu_ready, output, 1: the arbiter can accept an NPU result.
REQ-012 SHALL have port WR, output, 5: register file write address, registered.
REQ-013 SHALL have port WD, output, 32: register file write data, registered.
REQ-014 SHALL have port RegWrite, output, 1: register file write enable, registered.
REQ-015 SHALL have port stall, output, 1: pipeline freeze request (MEM/WB holds), registered.
REQ-016 SHALL have port fifo_count, output, $clog2(DEPTH)+1: number of occupied FIFO entries.

Function
REQ-017 SHALL accept an NPU result when npu_valid && npu_ready, where npu_ready = !rst && fifo_count < DEPTH.
- An accepted result with npu_rd==0 is discarded and not enqueued.
REQ-018 SHALL have an FSM with two states, RUN and DRAIN, with stall = (state==DRAIN).
REQ-019 In RUN, the write source SHALL be chosen by priority:
- First: pipeline, if wb_we && wb_rd!=0.
- Else: FIFO head pop, if the FIFO is non-empty.
- Else: no write.
- The selected write appears on WR/WD/RegWrite in the next cycle (latency 1).
REQ-020 In DRAIN, the arbiter SHALL ignore wb_we, because the frozen MEM/WB re-presents the same write after DRAIN.
- The FIFO head is popped if the FIFO is non-empty.
- DRAIN always returns to RUN after exactly one cycle.
REQ-021 SHALL apply these write-address rules:
- A pipeline write with wb_rd==0 produces RegWrite=0.
- A popped entry flagged squashed produces RegWrite=0 and still frees its slot.
REQ-022 Whenever a pipeline write to rd X is selected, the arbiter SHALL set the squash flag on every FIFO entry with rd X, because the pipeline write is architecturally newer.
- This includes an entry being enqueued in the same cycle.
REQ-023 SHALL NOT bypass the FIFO: an NPU result is written no earlier than the cycle after acceptance (minimum enqueue-to-RegWrite latency 2).
REQ-024 SHALL handle simultaneous push and pop with fifo_count unchanged.
- Pointers wrap modulo DEPTH.
- FIFO order is strict FIFO.
REQ-025 SHALL maintain an age counter:
- Increments each RUN cycle in which the FIFO is non-empty and no pop occurs.
- Clears on any pop or when the FIFO is empty.
- Saturates at AGE_MAX-1.
REQ-026 RUN SHALL transition to DRAIN in the next cycle when either condition holds:
- age == AGE_MAX-1 and the FIFO is non-empty.
- fifo_count == DEPTH and a pipeline write is selected this cycle.
REQ-027 SHALL hold WR and WD at their last values when RegWrite=0.

Reset
REQ-028 While rst=1, the following SHALL hold immediately, without waiting for a clock edge:
- WR=0, WD=0, RegWrite=0, stall=0.
- npu_ready=0, fifo_count=0.
- FIFO pointers 0, all squash flags 0, age 0, state RUN.
REQ-029 Reset asserted mid-operation SHALL discard all queued NPU results.
- The first clock after rst deasserts behaves as RUN with an empty FIFO.

Verification
REQ-030 The bench SHALL cover the basic pipeline write: wb_we=1, wb_rd=5, wb_data=0x1234 -> next cycle WR=5, WD=0x1234, RegWrite=1.
REQ-031 The bench SHALL cover an NPU result on an idle pipeline: npu_valid=1, npu_rd=7, npu_data=0xCAFE at cycle t -> RegWrite=1, WR=7, WD=0xCAFE at t+2; fifo_count 1 at t+1, 0 at t+2.
REQ-032 The bench SHALL cover squash:
- Stimulus: enqueue rd=9 data=0xAAAA; wb_we=1, wb_rd=9 every cycle for AGE_MAX cycles.
- Response: stall pulses one cycle, the pop occurs with RegWrite=0, and the register file never sees 0xAAAA.
REQ-033 The bench SHALL cover full FIFO:
- Stimulus: 4 NPU results accepted while wb_we=1 to distinct rd != queued rd.
- Response: npu_ready=0 at fifo_count=4, stall=1 next cycle, one pop in DRAIN, npu_ready=1 after.
REQ-034 The bench SHALL cover x0 writes: wb_rd=0 or npu_rd=0 -> RegWrite stays 0 and fifo_count is unchanged.
REQ-035 The bench SHALL cover reset mid-operation: rst pulsed with fifo_count=3 and stall=1 -> all outputs 0 immediately; after release, no queued write ever appears.
